tl45_execute: RTL and testbench

- Execute stage, directly downstream of register read, upstream of memory/writeback.
- Consumes the register-read output buffer. Waits on unresolved source operands by snooping forwarding buses. Performs ALU ops, keeps the 4-bit flags register, resolves conditional jumps.
- Produces a registered result buffer plus a forwarding bus for the stages behind it.

---
 rtl/tl45_execute_if.sv | 42 ++++
 rtl/tl45_execute.sv | 215 +++++++++++++++++++++
 tb/tb_tl45_execute.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl45_execute_if.sv
// Register-read -> execute -> memory stage bus for the TL45 execute stage.
// master drives the instruction side and consumes results; slave is the execute stage.
interface tl45_execute_if;
    logic        i_pipe_stall;
    logic        o_pipe_stall;
    logic        i_pipe_flush;
    logic        o_pipe_flush;
    logic [4:0]  i_opcode;
    logic [3:0]  i_dr;
    logic [3:0]  i_sr1;
    logic [3:0]  i_sr2;
    logic [31:0] i_sr1_val;
    logic [31:0] i_sr2_val;
    logic [31:0] i_pc;
    logic [3:0]  i_of1_reg;
    logic [3:0]  i_of2_reg;
    logic [31:0] i_of1_data;
    logic [31:0] i_of2_data;
    logic [4:0]  o_opcode;
    logic [3:0]  o_dr;
    logic [31:0] o_value;
    logic [31:0] o_sr2_val;
    logic [31:0] o_pc;
    logic [3:0]  o_of_reg;
    logic [31:0] o_of_data;
    logic        o_br_taken;
    logic [31:0] o_br_pc;

    modport master (
        output i_pipe_stall, i_pipe_flush, i_opcode, i_dr, i_sr1, i_sr2,
               i_sr1_val, i_sr2_val, i_pc, i_of1_reg, i_of2_reg, i_of1_data, i_of2_data,
        input  o_pipe_stall, o_pipe_flush, o_opcode, o_dr, o_value, o_sr2_val,
               o_pc, o_of_reg, o_of_data, o_br_taken, o_br_pc
    );

    modport slave (
        input  i_pipe_stall, i_pipe_flush, i_opcode, i_dr, i_sr1, i_sr2,
               i_sr1_val, i_sr2_val, i_pc, i_of1_reg, i_of2_reg, i_of1_data, i_of2_data,
        output o_pipe_stall, o_pipe_flush, o_opcode, o_dr, o_value, o_sr2_val,
               o_pc, o_of_reg, o_of_data, o_br_taken, o_br_pc
    );
endinterface

// File: rtl/tl45_execute.sv
// TL45 execute stage: operand wait/snoop, ALU with {Z,N,C,V} flags, conditional jump
// resolution and a registered result buffer with its own forwarding bus.
module tl45_execute (
    input  logic          i_clk,
    input  logic          i_reset,
    tl45_execute_if.slave bus
);
    localparam logic [4:0] OP_ADD = 5'h01, OP_SUB = 5'h02, OP_AND = 5'h04, OP_OR  = 5'h05,
                           OP_XOR = 5'h06, OP_SHL = 5'h07, OP_SHR = 5'h08, OP_JMP = 5'h0C,
                           OP_SW  = 5'h14, OP_LW  = 5'h15;

    typedef enum logic {S_RUN, S_WAIT} state_t;
    state_t state, state_nx;

    logic [4:0]  h_opcode;
    logic [3:0]  h_dr, h_sr1, h_sr2;
    logic [31:0] h_a, h_b, h_pc;
    logic        f_z, f_n, f_c, f_v;
    logic        f_z_nx, f_n_nx, f_c_nx, f_v_nx;

    logic [4:0]  r_opcode, nx_opcode;
    logic [3:0]  r_dr, nx_dr, r_of_reg, nx_of_reg;
    logic [31:0] r_value, nx_value, r_sr2_val, nx_sr2_val, r_pc, nx_pc;
    logic [31:0] r_of_data, nx_of_data, r_br_pc, nx_br_pc;
    logic        r_br_taken, nx_br_taken;

    logic [4:0]  sel_op;
    logic [3:0]  sel_dr, sel_sr1, sel_sr2, op_sr1, op_sr2;
    logic [31:0] sel_a, sel_b, sel_pc, op_a, op_b, alu_res;
    logic [32:0] sn1, sn2, sum;
    logic        squash, run_pending, do_latch, exec, is_alu, alu_c, alu_v, jmp_cond;

    function automatic logic [32:0] snoop(input logic [3:0] want,
                                          input logic [3:0] r0, input logic [31:0] d0,
                                          input logic [3:0] r1, input logic [31:0] d1,
                                          input logic [3:0] r2, input logic [31:0] d2);
        logic [32:0] res;
        res = '0;
        if (want != 4'd0) begin
            if (r0 != 4'd0 && r0 == want)      res = {1'b1, d0};
            else if (r1 != 4'd0 && r1 == want) res = {1'b1, d1};
            else if (r2 != 4'd0 && r2 == want) res = {1'b1, d2};
        end
        return res;
    endfunction

    always_comb begin
        sel_op  = (state == S_RUN) ? bus.i_opcode    : h_opcode;
        sel_dr  = (state == S_RUN) ? bus.i_dr        : h_dr;
        sel_sr1 = (state == S_RUN) ? bus.i_sr1       : h_sr1;
        sel_sr2 = (state == S_RUN) ? bus.i_sr2       : h_sr2;
        sel_a   = (state == S_RUN) ? bus.i_sr1_val   : h_a;
        sel_b   = (state == S_RUN) ? bus.i_sr2_val   : h_b;
        sel_pc  = (state == S_RUN) ? bus.i_pc        : h_pc;

        // Snooping also runs in the latch cycle: the own bus is overwritten by the
        // bubble we emit, so a back-to-back dependency must be caught here.
        sn1 = snoop(sel_sr1, r_of_reg, r_of_data, bus.i_of1_reg, bus.i_of1_data,
                    bus.i_of2_reg, bus.i_of2_data);
        sn2 = snoop(sel_sr2, r_of_reg, r_of_data, bus.i_of1_reg, bus.i_of1_data,
                    bus.i_of2_reg, bus.i_of2_data);
        op_a   = sn1[32] ? sn1[31:0] : sel_a;
        op_b   = sn2[32] ? sn2[31:0] : sel_b;
        op_sr1 = sn1[32] ? 4'd0 : sel_sr1;
        op_sr2 = sn2[32] ? 4'd0 : sel_sr2;

        squash      = (state == S_RUN) && r_br_taken;
        run_pending = (bus.i_sr1 != 4'd0) || (bus.i_sr2 != 4'd0);
        do_latch    = (state == S_RUN) && !squash && run_pending;
        if (state == S_RUN) exec = !squash && !run_pending;
        else                exec = (op_sr1 == 4'd0) && (op_sr2 == 4'd0);

        state_nx = state;
        if (do_latch)                    state_nx = S_WAIT;
        else if (state == S_WAIT && exec) state_nx = S_RUN;

        sum     = {1'b0, op_a} + {1'b0, op_b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        is_alu  = 1'b1;
        case (sel_op)
            OP_ADD: begin
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = (op_a[31] == op_b[31]) && (alu_res[31] != op_a[31]);
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                alu_c   = op_a < op_b;
                alu_v   = (op_a[31] != op_b[31]) && (alu_res[31] != op_a[31]);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SHL:  alu_res = op_a << op_b[4:0];
            OP_SHR:  alu_res = op_a >> op_b[4:0];
            default: is_alu  = 1'b0;
        endcase

        case (sel_dr)
            4'd0:    jmp_cond = 1'b1;
            4'd1:    jmp_cond = f_z;
            4'd2:    jmp_cond = !f_z;
            4'd3:    jmp_cond = f_n;
            4'd4:    jmp_cond = !f_n;
            4'd5:    jmp_cond = f_c;
            4'd6:    jmp_cond = f_v;
            default: jmp_cond = 1'b0;
        endcase

        nx_opcode   = '0;
        nx_dr       = '0;
        nx_value    = '0;
        nx_sr2_val  = '0;
        nx_pc       = '0;
        nx_of_reg   = '0;
        nx_of_data  = '0;
        nx_br_taken = 1'b0;
        nx_br_pc    = '0;
        f_z_nx = f_z;
        f_n_nx = f_n;
        f_c_nx = f_c;
        f_v_nx = f_v;
        if (exec) begin
            if (is_alu) begin
                nx_opcode  = sel_op;
                nx_dr      = sel_dr;
                nx_value   = alu_res;
                nx_pc      = sel_pc;
                nx_of_reg  = sel_dr;
                nx_of_data = alu_res;
                f_z_nx = (alu_res == 32'd0);
                f_n_nx = alu_res[31];
                f_c_nx = alu_c;
                f_v_nx = alu_v;
            end else if (sel_op == OP_LW || sel_op == OP_SW) begin
                nx_opcode  = sel_op;
                nx_dr      = sel_dr;
                nx_value   = sum[31:0];
                nx_sr2_val = op_b;
                nx_pc      = sel_pc;
            end else if (sel_op == OP_JMP) begin
                nx_opcode   = OP_JMP;
                nx_pc       = sel_pc;
                nx_br_taken = jmp_cond;
                nx_br_pc    = sum[31:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || bus.i_pipe_flush) begin
            state      <= S_RUN;
            h_opcode   <= '0;
            h_dr       <= '0;
            h_sr1      <= '0;
            h_sr2      <= '0;
            h_a        <= '0;
            h_b        <= '0;
            h_pc       <= '0;
            r_opcode   <= '0;
            r_dr       <= '0;
            r_value    <= '0;
            r_sr2_val  <= '0;
            r_pc       <= '0;
            r_of_reg   <= '0;
            r_of_data  <= '0;
            r_br_taken <= 1'b0;
            r_br_pc    <= '0;
            if (i_reset) begin
                f_z <= 1'b0;
                f_n <= 1'b0;
                f_c <= 1'b0;
                f_v <= 1'b0;
            end
        end else if (!bus.i_pipe_stall) begin
            state <= state_nx;
            if (do_latch || state == S_WAIT) begin
                h_opcode <= sel_op;
                h_dr     <= sel_dr;
                h_sr1    <= op_sr1;
                h_sr2    <= op_sr2;
                h_a      <= op_a;
                h_b      <= op_b;
                h_pc     <= sel_pc;
            end
            r_opcode   <= nx_opcode;
            r_dr       <= nx_dr;
            r_value    <= nx_value;
            r_sr2_val  <= nx_sr2_val;
            r_pc       <= nx_pc;
            r_of_reg   <= nx_of_reg;
            r_of_data  <= nx_of_data;
            r_br_taken <= nx_br_taken;
            r_br_pc    <= nx_br_pc;
            f_z <= f_z_nx;
            f_n <= f_n_nx;
            f_c <= f_c_nx;
            f_v <= f_v_nx;
        end
    end

    assign bus.o_pipe_stall = bus.i_pipe_stall | (state == S_WAIT);
    assign bus.o_pipe_flush = bus.i_pipe_flush | r_br_taken;
    assign bus.o_opcode     = r_opcode;
    assign bus.o_dr         = r_dr;
    assign bus.o_value      = r_value;
    assign bus.o_sr2_val    = r_sr2_val;
    assign bus.o_pc         = r_pc;
    assign bus.o_of_reg     = r_of_reg;
    assign bus.o_of_data    = r_of_data;
    assign bus.o_br_taken   = r_br_taken;
    assign bus.o_br_pc      = r_br_pc;
endmodule

// File: tb/tb_tl45_execute.sv
// Bench for tl45_execute: vector table plus hand sequences for operand waits,
// flush/reset in WAIT and downstream stall, with a scoreboard of produced results.
module tb_tl45_execute;
    localparam logic [4:0] OP_NOP = 5'h00, OP_ADD = 5'h01, OP_SUB = 5'h02, OP_AND = 5'h04,
                           OP_OR  = 5'h05, OP_XOR = 5'h06, OP_SHL = 5'h07, OP_SHR = 5'h08,
                           OP_JMP = 5'h0C, OP_SW  = 5'h14, OP_LW  = 5'h15;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  dr;
        logic [31:0] value;
        logic [31:0] sr2;
        logic [31:0] pc;
        logic [3:0]  of_reg;
        logic [31:0] of_data;
        logic        br_taken;
        logic [31:0] br_pc;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  dr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        bit          prod;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tl45_execute_if bus ();
    tl45_execute dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    exp_t        sb[$];
    vec_t        tbl[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_out = 0;
    bit          held_edge = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] op, input logic [3:0] dr, input logic [31:0] val,
                                input logic [31:0] sr2, input logic [31:0] pc, input logic [3:0] ofr,
                                input logic [31:0] ofd, input logic bt, input logic [31:0] bpc);
        exp_t e;
        e = '{op: op, dr: dr, value: val, sr2: sr2, pc: pc, of_reg: ofr, of_data: ofd,
              br_taken: bt, br_pc: bpc};
        return e;
    endfunction

    function automatic exp_t alu_exp(input logic [4:0] op, input logic [3:0] dr,
                                     input logic [31:0] val, input logic [31:0] pc);
        return mk(op, dr, val, 32'd0, pc, dr, val, 1'b0, 32'd0);
    endfunction

    function automatic exp_t jmp_exp(input logic tk, input logic [31:0] tgt, input logic [31:0] pc);
        return mk(OP_JMP, 4'd0, 32'd0, 32'd0, pc, 4'd0, 32'd0, tk, tgt);
    endfunction

    task automatic add(input logic [4:0] op, input logic [3:0] dr, input logic [31:0] a,
                       input logic [31:0] b, input bit prod, input logic [31:0] val,
                       input logic tk, input logic [31:0] tgt);
        vec_t v;
        v.op = op; v.dr = dr; v.a = a; v.b = b; v.prod = prod;
        v.pc = 32'h1000 + 32'(tbl.size()) * 32'd4;
        if (op == OP_JMP)                  v.e = jmp_exp(tk, tgt, v.pc);
        else if (op == OP_LW || op == OP_SW) v.e = mk(op, dr, val, b, v.pc, 4'd0, 32'd0, 1'b0, 32'd0);
        else                               v.e = alu_exp(op, dr, val, v.pc);
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [4:0] op, input logic [3:0] dr, input logic [3:0] sr1,
                         input logic [3:0] sr2, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc);
        bus.i_opcode = op;  bus.i_dr = dr;  bus.i_sr1 = sr1;  bus.i_sr2 = sr2;
        bus.i_sr1_val = a;  bus.i_sr2_val = b;  bus.i_pc = pc;
    endtask

    task automatic nop();
        drive(OP_NOP, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic fwd(input logic [3:0] r1, input logic [31:0] d1,
                       input logic [3:0] r2, input logic [31:0] d2);
        bus.i_of1_reg = r1;  bus.i_of1_data = d1;  bus.i_of2_reg = r2;  bus.i_of2_data = d2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out();
        exp_t e;
        bit   ok;
        n_cmp++;
        n_out++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output#%0d: got op=%h dr=%h val=%h pc=%h br=%b expected no output",
                     n_out, bus.o_opcode, bus.o_dr, bus.o_value, bus.o_pc, bus.o_br_taken);
        end else begin
            e  = sb.pop_front();
            ok = (bus.o_opcode === e.op) && (bus.o_dr === e.dr) && (bus.o_pc === e.pc) &&
                 (bus.o_of_reg === e.of_reg) && (bus.o_br_taken === e.br_taken);
            if (e.of_reg != 4'd0) ok = ok && (bus.o_of_data === e.of_data);
            if (e.op != OP_JMP)   ok = ok && (bus.o_value === e.value);
            if (e.op == OP_LW || e.op == OP_SW) ok = ok && (bus.o_sr2_val === e.sr2);
            if (e.br_taken) ok = ok && (bus.o_br_pc === e.br_pc) && (bus.o_pipe_flush === 1'b1);
            if (!ok) begin
                n_bad++;
                $display("FAIL result#%0d: got op=%h dr=%h val=%h sr2=%h pc=%h of=%h/%h br=%b/%h flush=%b expected op=%h dr=%h val=%h sr2=%h pc=%h of=%h/%h br=%b/%h",
                         n_out, bus.o_opcode, bus.o_dr, bus.o_value, bus.o_sr2_val, bus.o_pc,
                         bus.o_of_reg, bus.o_of_data, bus.o_br_taken, bus.o_br_pc, bus.o_pipe_flush,
                         e.op, e.dr, e.value, e.sr2, e.pc, e.of_reg, e.of_data, e.br_taken, e.br_pc);
            end
        end
    endtask

    // Outputs only change on unstalled, non-reset edges; anything non-bubble then is a result.
    always @(posedge clk) held_edge = bus.i_pipe_stall && !rst && !bus.i_pipe_flush;
    always @(negedge clk)
        if (!rst && !held_edge && (bus.o_opcode != 5'd0 || bus.o_br_taken)) check_out();

    initial begin
        nop();
        fwd(4'd0, 32'd0, 4'd0, 32'd0);
        bus.i_pipe_stall = 1'b0;
        bus.i_pipe_flush = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_opcode", 32'(bus.o_opcode), 32'd0);
        chk("rst_value", bus.o_value, 32'd0);
        chk("rst_of_reg", 32'(bus.o_of_reg), 32'd0);
        chk("rst_br", {bus.o_br_taken, bus.o_pipe_stall, bus.o_pipe_flush}, 32'd0);
        step();

        // Single-cycle ADD latency
        drive(OP_ADD, 4'd3, 4'd0, 4'd0, 32'd5, 32'd7, 32'h40);
        sb.push_back(alu_exp(OP_ADD, 4'd3, 32'd12, 32'h40));
        @(negedge clk);
        chk("add_stall", 32'(bus.o_pipe_stall), 32'd0);
        step();
        nop();
        @(negedge clk);
        chk("add_value", bus.o_value, 32'd12);
        chk("add_of_reg", 32'(bus.o_of_reg), 32'd3);
        step();

        add(OP_JMP, 4'd1, 32'h200, 32'h0, 1, 0, 1'b0, 32'h200);
        add(OP_SUB, 4'd1, 32'd9, 32'd9, 1, 32'd0, 0, 0);
        add(OP_JMP, 4'd1, 32'h100, 32'h20, 1, 0, 1'b1, 32'h120);
        add(OP_ADD, 4'd2, 32'd1, 32'd1, 0, 0, 0, 0);
        add(OP_JMP, 4'd5, 32'h0, 32'h300, 1, 0, 1'b0, 32'h300);
        add(OP_ADD, 4'd4, 32'hFFFFFFFF, 32'd1, 1, 32'd0, 0, 0);
        add(OP_JMP, 4'd5, 32'h10, 32'h0, 1, 0, 1'b1, 32'h10);
        add(OP_OR, 4'd9, 32'd1, 32'd2, 0, 0, 0, 0);
        add(OP_ADD, 4'd6, 32'h7FFFFFFF, 32'd1, 1, 32'h80000000, 0, 0);
        add(OP_JMP, 4'd6, 32'h1000, 32'h4, 1, 0, 1'b1, 32'h1004);
        add(OP_SUB, 4'd7, 32'd5, 32'd1, 0, 0, 0, 0);
        add(OP_JMP, 4'd3, 32'h2000, 32'h0, 1, 0, 1'b1, 32'h2000);
        add(OP_NOP, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        add(OP_SUB, 4'd8, 32'd3, 32'd5, 1, 32'hFFFFFFFE, 0, 0);
        add(OP_JMP, 4'd4, 32'h30, 32'h0, 1, 0, 1'b0, 32'h30);
        add(OP_JMP, 4'd7, 32'h40, 32'h0, 1, 0, 1'b0, 32'h40);
        add(OP_AND, 4'd9, 32'hF0F0, 32'hFF00, 1, 32'hF000, 0, 0);
        add(OP_OR, 4'd10, 32'hF0F0, 32'h0F00, 1, 32'hFFF0, 0, 0);
        add(OP_XOR, 4'd11, 32'hFF, 32'h0F, 1, 32'hF0, 0, 0);
        add(OP_SHL, 4'd12, 32'd1, 32'h24, 1, 32'h10, 0, 0);
        add(OP_SHR, 4'd13, 32'h80000000, 32'd31, 1, 32'd1, 0, 0);
        add(OP_LW, 4'd14, 32'h1000, 32'h10, 1, 32'h1010, 0, 0);
        add(OP_SW, 4'd0, 32'h2000, 32'h8, 1, 32'h2008, 0, 0);
        add(OP_JMP, 4'd2, 32'hFFFFFFF0, 32'h20, 1, 0, 1'b1, 32'h10);
        add(OP_ADD, 4'd3, 32'd2, 32'd2, 0, 0, 0, 0);
        add(5'h1F, 4'd3, 32'd1, 32'd1, 0, 0, 0, 0);
        add(OP_JMP, 4'd0, 32'h44, 32'h0, 1, 0, 1'b1, 32'h44);
        add(OP_NOP, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        add(OP_SUB, 4'd15, 32'h80000000, 32'd1, 1, 32'h7FFFFFFF, 0, 0);
        add(OP_JMP, 4'd6, 32'h50, 32'h0, 1, 0, 1'b1, 32'h50);
        add(OP_NOP, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].dr, 4'd0, 4'd0, tbl[i].a, tbl[i].b, tbl[i].pc);
            if (tbl[i].prod) sb.push_back(tbl[i].e);
            @(negedge clk);
            chk("tbl_stall", 32'(bus.o_pipe_stall), 32'd0);
            step();
        end
        nop();
        step();

        // Pending sr1 resolved from the external bus 2 two cycles later
        drive(OP_ADD, 4'd7, 4'd4, 4'd0, 32'd0, 32'd1, 32'h3000);
        sb.push_back(alu_exp(OP_ADD, 4'd7, 32'h11, 32'h3000));
        @(negedge clk);
        chk("pend_accept_stall", 32'(bus.o_pipe_stall), 32'd0);
        step();
        nop();
        @(negedge clk);
        chk("pend_w1_stall", 32'(bus.o_pipe_stall), 32'd1);
        chk("pend_w1_bubble", 32'(bus.o_opcode), 32'd0);
        step();
        fwd(4'd0, 32'd0, 4'd4, 32'h10);
        @(negedge clk);
        chk("pend_w2_stall", 32'(bus.o_pipe_stall), 32'd1);
        chk("pend_w2_bubble", 32'(bus.o_opcode), 32'd0);
        step();
        fwd(4'd0, 32'd0, 4'd0, 32'd0);
        @(negedge clk);
        chk("pend_done_stall", 32'(bus.o_pipe_stall), 32'd0);
        chk("pend_value", bus.o_value, 32'h11);
        step();

        // Both operands pending; bus 1 wins over bus 2 for the same register
        drive(OP_SUB, 4'd8, 4'd3, 4'd6, 32'd0, 32'd0, 32'h3100);
        sb.push_back(alu_exp(OP_SUB, 4'd8, 32'd70, 32'h3100));
        step();
        nop();
        fwd(4'd3, 32'd100, 4'd3, 32'd999);
        step();
        fwd(4'd0, 32'd0, 4'd6, 32'd30);
        @(negedge clk);
        chk("prio_wait_stall", 32'(bus.o_pipe_stall), 32'd1);
        step();
        fwd(4'd0, 32'd0, 4'd0, 32'd0);
        @(negedge clk);
        chk("prio_value", bus.o_value, 32'd70);
        step();

        // Back-to-back dependency resolved from the stage's own forwarding bus
        drive(OP_ADD, 4'd5, 4'd0, 4'd0, 32'd1, 32'd1, 32'h3200);
        sb.push_back(alu_exp(OP_ADD, 4'd5, 32'd2, 32'h3200));
        step();
        drive(OP_SUB, 4'd9, 4'd5, 4'd0, 32'd0, 32'd3, 32'h3204);
        sb.push_back(alu_exp(OP_SUB, 4'd9, 32'hFFFFFFFF, 32'h3204));
        step();
        nop();
        step();
        @(negedge clk);
        chk("dep_resolved_stall", 32'(bus.o_pipe_stall), 32'd0);
        chk("dep_value", bus.o_value, 32'hFFFFFFFF);
        step();

        // Flush in WAIT drops the held instruction; flags survive the flush
        drive(OP_SUB, 4'd1, 4'd0, 4'd0, 32'd0, 32'd1, 32'h3300);
        sb.push_back(alu_exp(OP_SUB, 4'd1, 32'hFFFFFFFF, 32'h3300));
        step();
        drive(OP_ADD, 4'd2, 4'd4, 4'd0, 32'd0, 32'd1, 32'h3304);
        step();
        nop();
        bus.i_pipe_flush = 1'b1;
        @(negedge clk);
        chk("flush_out", 32'(bus.o_pipe_flush), 32'd1);
        step();
        bus.i_pipe_flush = 1'b0;
        @(negedge clk);
        chk("flush_stall", 32'(bus.o_pipe_stall), 32'd0);
        chk("flush_opcode", 32'(bus.o_opcode), 32'd0);
        chk("flush_value", bus.o_value, 32'd0);
        drive(OP_JMP, 4'd3, 4'd0, 4'd0, 32'h60, 32'h0, 32'h3308);
        sb.push_back(jmp_exp(1'b1, 32'h60, 32'h3308));
        step();
        nop();
        step();
        drive(OP_ADD, 4'd3, 4'd0, 4'd0, 32'd2, 32'd3, 32'h3310);
        sb.push_back(alu_exp(OP_ADD, 4'd3, 32'd5, 32'h3310));
        step();
        nop();
        @(negedge clk);
        chk("post_flush_value", bus.o_value, 32'd5);
        step();

        // Reset in WAIT clears state, outputs and flags
        drive(OP_SUB, 4'd1, 4'd0, 4'd0, 32'd0, 32'd1, 32'h3400);
        sb.push_back(alu_exp(OP_SUB, 4'd1, 32'hFFFFFFFF, 32'h3400));
        step();
        drive(OP_ADD, 4'd2, 4'd4, 4'd0, 32'd0, 32'd1, 32'h3404);
        step();
        nop();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_stall", 32'(bus.o_pipe_stall), 32'd0);
        chk("rstw_opcode", 32'(bus.o_opcode), 32'd0);
        drive(OP_JMP, 4'd5, 4'd0, 4'd0, 32'h70, 32'h0, 32'h3408);
        sb.push_back(jmp_exp(1'b0, 32'h70, 32'h3408));
        step();
        drive(OP_JMP, 4'd3, 4'd0, 4'd0, 32'h74, 32'h0, 32'h340C);
        sb.push_back(jmp_exp(1'b0, 32'h74, 32'h340C));
        step();
        drive(OP_JMP, 4'd2, 4'd0, 4'd0, 32'h80, 32'h0, 32'h3410);
        sb.push_back(jmp_exp(1'b1, 32'h80, 32'h3410));
        step();
        nop();
        step();

        // Downstream stall holds everything for three cycles
        drive(OP_XOR, 4'd2, 4'd0, 4'd0, 32'hA, 32'h5, 32'h3500);
        sb.push_back(alu_exp(OP_XOR, 4'd2, 32'hF, 32'h3500));
        step();
        drive(OP_ADD, 4'd3, 4'd0, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3504);
        sb.push_back(alu_exp(OP_ADD, 4'd3, 32'hFFFFFFFE, 32'h3504));
        bus.i_pipe_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("stall_hold_value", bus.o_value, 32'hF);
            chk("stall_hold_dr", 32'(bus.o_dr), 32'd2);
            chk("stall_out", 32'(bus.o_pipe_stall), 32'd1);
        end
        bus.i_pipe_stall = 1'b0;
        step();
        nop();
        @(negedge clk);
        chk("stall_release_value", bus.o_value, 32'hFFFFFFFE);
        drive(OP_JMP, 4'd5, 4'd0, 4'd0, 32'h90, 32'h0, 32'h3508);
        sb.push_back(jmp_exp(1'b1, 32'h90, 32'h3508));
        step();
        nop();
        repeat (3) step();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
